remote_comm: RTL and testbench

Host-side command transmitter for the maze runner's BLE UART link. Accepts a 16-bit command, serializes it as two 8N1 bytes (high byte first) on `TX`, then waits for the robot's 1-byte response on `RX`. It sits in the test harness and remote-control side of the design, opposite the robot's command receiver. A response timeout flags a robot that never acknowledges.

---
 rtl/remote_comm_pkg.sv | 24 ++
 rtl/remote_comm_if.sv | 23 ++
 rtl/uart_xcvr.sv | 125 ++++++++++++
 rtl/remote_comm.sv | 130 +++++++++++++
 tb/tb_remote_comm.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the host-side BLE command transmitter.
package remote_comm_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned BAUD_DIV_DFLT = 2604;
  localparam int unsigned TMO_CYC_DFLT  = 1 << 22;

  localparam logic [BYTE_W-1:0] RESP_DONE = 8'hA5;
  localparam logic [BYTE_W-1:0] RESP_BUSY = 8'h5A;

  typedef enum logic [1:0] {
    IDLE,
    TX_HI,
    TX_LO,
    WAIT_RESP
  } rc_state_t;

  // Command word, high byte goes out first.
  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } rc_cmd_t;

endpackage

// File: rtl/remote_comm_if.sv
// Host-facing command/response port of remote_comm.
interface remote_comm_if;
  import remote_comm_pkg::*;

  logic              snd_cmd;
  rc_cmd_t           cmd;
  logic              clr_resp_rdy;
  logic              cmd_snt;
  logic [BYTE_W-1:0] resp;
  logic              resp_rdy;
  logic              busy;
  logic              tmo;

  modport master (
    output snd_cmd, cmd, clr_resp_rdy,
    input  cmd_snt, resp, resp_rdy, busy, tmo
  );

  modport slave (
    input  snd_cmd, cmd, clr_resp_rdy,
    output cmd_snt, resp, resp_rdy, busy, tmo
  );
endinterface

// File: rtl/uart_xcvr.sv
// 8N1 byte transmitter and receiver sharing one baud divisor.
// tx_done and rx_rdy are same-cycle strobes so callers can chain frames without a gap.
module uart_xcvr
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trmt,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_done,
  output logic              tx,
  input  logic              rx,
  output logic              rx_rdy,
  output logic [BYTE_W-1:0] rx_data
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned IDX_W = 4;
  localparam int unsigned HALF  = BAUD_DIV / 2;

  logic             tx_busy_q, tx_busy_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0] tx_idx_q, tx_idx_d;
  logic [8:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d;
  logic             tx_baud_end;

  logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
  logic             rx_busy_q, rx_busy_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0] rx_idx_q, rx_idx_d;
  logic [8:0]       rx_shift_q, rx_shift_d;
  logic             rx_smp;

  // Transmit: idx 0 is the start bit, 1..8 data, 9 stop; reload on done for gapless chaining.
  always_comb begin
    tx_busy_d   = tx_busy_q;
    tx_cnt_d    = tx_cnt_q;
    tx_idx_d    = tx_idx_q;
    tx_shift_d  = tx_shift_q;
    tx_d        = tx_q;
    tx_baud_end = tx_busy_q && (tx_cnt_q == CNT_W'(BAUD_DIV - 1));
    tx_done     = tx_baud_end && (tx_idx_q == IDX_W'(9));
    if (tx_busy_q) tx_cnt_d = tx_baud_end ? '0 : tx_cnt_q + CNT_W'(1);
    if (tx_baud_end && !tx_done) begin
      tx_d       = tx_shift_q[0];
      tx_shift_d = {1'b1, tx_shift_q[8:1]};
      tx_idx_d   = tx_idx_q + IDX_W'(1);
    end
    if (tx_done) begin
      tx_busy_d = 1'b0;
      tx_d      = 1'b1;
    end
    if (trmt && (!tx_busy_q || tx_done)) begin
      tx_busy_d  = 1'b1;
      tx_d       = 1'b0;
      tx_shift_d = {1'b1, tx_data};
      tx_idx_d   = '0;
      tx_cnt_d   = '0;
    end
  end

  // Receive: sync, falling-edge start, mid-bit sampling; stop bit 0 discards the byte.
  always_comb begin
    rx_s1_d    = rx;
    rx_s2_d    = rx_s1_q;
    rx_s3_d    = rx_s2_q;
    rx_busy_d  = rx_busy_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_smp     = rx_busy_q && (rx_cnt_q == '0);
    rx_rdy     = rx_smp && (rx_idx_q == IDX_W'(9)) && rx_s2_q;
    if (!rx_busy_q) begin
      if (rx_s3_q && !rx_s2_q) begin
        rx_busy_d = 1'b1;
        rx_cnt_d  = CNT_W'(HALF - 1);
        rx_idx_d  = '0;
      end
    end else if (rx_smp) begin
      rx_cnt_d   = CNT_W'(BAUD_DIV - 1);
      rx_shift_d = {rx_s2_q, rx_shift_q[8:1]};
      rx_idx_d   = rx_idx_q + IDX_W'(1);
      if (rx_idx_q == IDX_W'(9)) rx_busy_d = 1'b0;
    end else begin
      rx_cnt_d = rx_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '1;
      tx_q       <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_s3_q    <= rx_s3_d;
      rx_busy_q  <= rx_busy_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  assign tx      = tx_q;
  assign rx_data = rx_shift_q[8:1];

endmodule

// File: rtl/remote_comm.sv
// Host-side command transmitter: sends a 16-bit command as two 8N1 bytes and
// waits for a one-byte robot response, flagging a timeout if none arrives.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DFLT,
  parameter int unsigned TMO_CYC  = TMO_CYC_DFLT
) (
  input  logic          clk,
  input  logic          rst,
  remote_comm_if.slave  bus,
  output logic          TX,
  input  logic          RX
);

  localparam int unsigned TMO_W = $clog2(TMO_CYC);

  rc_state_t         state_q, state_d;
  rc_cmd_t           cmd_q, cmd_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              cmd_snt_q, cmd_snt_d;
  logic [BYTE_W-1:0] resp_q, resp_d;
  logic              resp_rdy_q, resp_rdy_d;
  logic              busy_q, busy_d;
  logic              tmo_q, tmo_d;

  logic              trmt_c;
  logic [BYTE_W-1:0] tx_data_c;
  logic              tx_done;
  logic              rx_rdy;
  logic [BYTE_W-1:0] rx_data;
  logic              tmo_exp_c;

  uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt_c),
    .tx_data (tx_data_c),
    .tx_done (tx_done),
    .tx      (TX),
    .rx      (RX),
    .rx_rdy  (rx_rdy),
    .rx_data (rx_data)
  );

  // Framing FSM; a captured byte outranks both clr_resp_rdy and timeout expiry.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    tmo_cnt_d  = tmo_cnt_q;
    cmd_snt_d  = 1'b0;
    resp_d     = resp_q;
    resp_rdy_d = resp_rdy_q;
    tmo_d      = tmo_q;
    trmt_c     = 1'b0;
    tx_data_c  = cmd_q.lo;
    tmo_exp_c  = (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
    if (bus.clr_resp_rdy) resp_rdy_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.snd_cmd) begin
          state_d    = TX_HI;
          cmd_d      = bus.cmd;
          resp_rdy_d = 1'b0;
          tmo_d      = 1'b0;
          trmt_c     = 1'b1;
          tx_data_c  = bus.cmd.hi;
        end
      end
      TX_HI: begin
        if (tx_done) begin
          state_d   = TX_LO;
          trmt_c    = 1'b1;
          tx_data_c = cmd_q.lo;
        end
      end
      TX_LO: begin
        if (tx_done) begin
          state_d   = WAIT_RESP;
          cmd_snt_d = 1'b1;
          tmo_cnt_d = '0;
        end
      end
      WAIT_RESP: begin
        if (!tmo_exp_c) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (rx_rdy) begin
          state_d = IDLE;
        end else if (tmo_exp_c) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rx_rdy) begin
      resp_d     = rx_data;
      resp_rdy_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      tmo_cnt_q  <= '0;
      cmd_snt_q  <= 1'b0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tmo_cnt_q  <= tmo_cnt_d;
      cmd_snt_q  <= cmd_snt_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
      busy_q     <= busy_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.cmd_snt  = cmd_snt_q;
  assign bus.resp     = resp_q;
  assign bus.resp_rdy = resp_rdy_q;
  assign bus.busy     = busy_q;
  assign bus.tmo      = tmo_q;

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: TX frames and responses are scoreboarded against queued expectations.
module tb_remote_comm;
  import remote_comm_pkg::*;

  localparam int unsigned BAUD = 16;
  localparam int unsigned TMO  = 1000;

  logic clk = 1'b0;
  logic rst;
  logic TX;
  logic RX;

  remote_comm_if bus();

  remote_comm #(.BAUD_DIV(BAUD), .TMO_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .TX  (TX),
    .RX  (RX)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_resp[$];

  // TX line monitor: decode each 8N1 frame at bit centres and pop the expected byte.
  initial begin : tx_mon
    logic prev;
    logic [7:0] b;
    logic stp;
    logic ok;
    logic [7:0] e;
    prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        prev = 1'b1;
      end else if (prev === 1'b1 && TX === 1'b0) begin
        ok = 1'b1; b = '0; stp = 1'b0;
        for (int c = 1; c <= int'(BAUD / 2 + 9 * BAUD); c++) begin
          @(posedge clk); #1;
          if (rst) begin ok = 1'b0; break; end
          if (c >= int'(BAUD / 2) && ((c - int'(BAUD / 2)) % int'(BAUD)) == 0) begin
            if ((c - int'(BAUD / 2)) / int'(BAUD) == 9) stp = TX;
            else if ((c - int'(BAUD / 2)) / int'(BAUD) >= 1) b[(c - int'(BAUD / 2)) / int'(BAUD) - 1] = TX;
          end
        end
        if (ok) begin
          frames++;
          checks++;
          if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL tx_frame unexpected got %h stop %b want none", b, stp);
          end else begin
            e = exp_tx.pop_front();
            if ({stp, b} !== {1'b1, e}) begin
              errors++;
              $display("FAIL tx_frame got %h stop %b want %h stop 1", b, stp, e);
            end
          end
        end
        prev = TX;
      end else begin
        prev = TX;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [15:0] c);
    bus.cmd = c;
    bus.snd_cmd = 1'b1;
    exp_tx.push_back(c[15:8]);
    exp_tx.push_back(c[7:0]);
    @(posedge clk); #1;
    bus.snd_cmd = 1'b0;
  endtask

  task automatic wait_cmd_snt(output int n, output bit found);
    found = 1'b0;
    n = 0;
    while (!found && n < 1000) begin
      @(posedge clk); #1;
      n++;
      found = (bus.cmd_snt === 1'b1);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stp);
    logic [9:0] f;
    f = {stp, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (BAUD) @(posedge clk);
      #1;
    end
    RX = 1'b1;
  endtask

  task automatic wait_resp(output bit found);
    int n;
    n = 0;
    while (bus.resp_rdy !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    found = (bus.resp_rdy === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; RX = 1'b1;
    bus.snd_cmd = 1'b0; bus.clr_resp_rdy = 1'b0; bus.cmd = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (TX !== 1'b1)           begin errors++; $display("FAIL rst_tx got %b want 1", TX); end
    if (bus.resp !== 8'h00)    begin errors++; $display("FAIL rst_resp got %h want 00", bus.resp); end
    if (bus.cmd_snt !== 1'b0)  begin errors++; $display("FAIL rst_cmd_snt got %b want 0", bus.cmd_snt); end
    if (bus.resp_rdy !== 1'b0) begin errors++; $display("FAIL rst_resp_rdy got %b want 0", bus.resp_rdy); end
    if (bus.busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    if (bus.tmo !== 1'b0)      begin errors++; $display("FAIL rst_tmo got %b want 0", bus.tmo); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_send_resp();
    int n; bit found; logic [7:0] e;
    send_cmd(16'h1234);
    checks += 2;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL cyc1_busy got %b want 1", bus.busy); end
    if (TX !== 1'b0)       begin errors++; $display("FAIL cyc1_tx got %b want 0", TX); end
    wait_cmd_snt(n, found);
    checks++;
    if (!found || n + 1 != 321) begin errors++; $display("FAIL cmd_snt_cycle got %0d found %0d want 321", n + 1, found); end
    @(posedge clk); #1;
    checks++;
    if (bus.cmd_snt !== 1'b0) begin errors++; $display("FAIL cmd_snt_width got %b want 0", bus.cmd_snt); end
    exp_resp.push_back(RESP_DONE);
    send_rx(RESP_DONE, 1'b1);
    wait_resp(found);
    e = exp_resp.pop_front();
    checks += 4;
    if (!found)            begin errors++; $display("FAIL resp_rdy got 0 want 1"); end
    if (bus.resp !== e)    begin errors++; $display("FAIL resp got %h want %h", bus.resp, e); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL resp_busy got %b want 0", bus.busy); end
    if (exp_tx.size() != 0) begin errors++; $display("FAIL tx_pending got %0d want 0", exp_tx.size()); end
  endtask

  task automatic test_busy_ignore();
    int n; bit found; int f0; logic [7:0] e;
    f0 = frames;
    send_cmd(16'h1234);
    repeat (200) @(posedge clk);
    #1;
    bus.cmd = 16'hFFFF; bus.snd_cmd = 1'b1;
    @(posedge clk); #1;
    bus.snd_cmd = 1'b0;
    wait_cmd_snt(n, found);
    checks++;
    if (!found) begin errors++; $display("FAIL ign_cmd_snt got none want pulse"); end
    exp_resp.push_back(RESP_DONE);
    send_rx(RESP_DONE, 1'b1);
    wait_resp(found);
    e = exp_resp.pop_front();
    repeat (400) @(posedge clk);
    #1;
    checks += 3;
    if (bus.resp !== e)     begin errors++; $display("FAIL ign_resp got %h want %h", bus.resp, e); end
    if (frames - f0 != 2)   begin errors++; $display("FAIL ign_frames got %0d want 2", frames - f0); end
    if (bus.busy !== 1'b0)  begin errors++; $display("FAIL ign_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_timeout();
    int n; int k; bit found; logic [7:0] e;
    send_cmd(16'h0001);
    wait_cmd_snt(n, found);
    k = 0;
    while (bus.tmo !== 1'b1 && k < 1500) begin @(posedge clk); #1; k++; end
    checks += 3;
    if (k != 1000)             begin errors++; $display("FAIL tmo_delay got %0d want 1000", k); end
    if (bus.busy !== 1'b0)     begin errors++; $display("FAIL tmo_busy got %b want 0", bus.busy); end
    if (bus.resp_rdy !== 1'b0) begin errors++; $display("FAIL tmo_resp_rdy got %b want 0", bus.resp_rdy); end
    send_cmd(16'h0002);
    checks += 2;
    if (bus.tmo !== 1'b0)  begin errors++; $display("FAIL tmo_clear got %b want 0", bus.tmo); end
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL tmo_rearm_busy got %b want 1", bus.busy); end
    wait_cmd_snt(n, found);
    exp_resp.push_back(RESP_DONE);
    send_rx(RESP_DONE, 1'b1);
    wait_resp(found);
    e = exp_resp.pop_front();
    checks++;
    if (!found || bus.resp !== e) begin errors++; $display("FAIL tmo_after_resp got %h want %h", bus.resp, e); end
  endtask

  task automatic test_framing();
    bit found; logic [7:0] e;
    bus.clr_resp_rdy = 1'b1;
    @(posedge clk); #1;
    bus.clr_resp_rdy = 1'b0;
    checks++;
    if (bus.resp_rdy !== 1'b0) begin errors++; $display("FAIL clr_resp_rdy got %b want 0", bus.resp_rdy); end
    send_rx(RESP_BUSY, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    checks += 2;
    if (bus.resp_rdy !== 1'b0) begin errors++; $display("FAIL frm_resp_rdy got %b want 0", bus.resp_rdy); end
    if (bus.resp !== RESP_DONE) begin errors++; $display("FAIL frm_resp got %h want %h", bus.resp, RESP_DONE); end
    repeat (2 * BAUD) @(posedge clk);
    #1;
    exp_resp.push_back(RESP_DONE);
    send_rx(RESP_DONE, 1'b1);
    wait_resp(found);
    e = exp_resp.pop_front();
    checks += 2;
    if (!found)         begin errors++; $display("FAIL frm_valid_rdy got 0 want 1"); end
    if (bus.resp !== e) begin errors++; $display("FAIL frm_valid_resp got %h want %h", bus.resp, e); end
  endtask

  task automatic test_reset_mid();
    int n; bit found; logic [7:0] e;
    send_cmd(16'h1234);
    repeat (80) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 6;
    if (TX !== 1'b1)           begin errors++; $display("FAIL mid_tx got %b want 1", TX); end
    if (bus.busy !== 1'b0)     begin errors++; $display("FAIL mid_busy got %b want 0", bus.busy); end
    if (bus.cmd_snt !== 1'b0)  begin errors++; $display("FAIL mid_cmd_snt got %b want 0", bus.cmd_snt); end
    if (bus.resp !== 8'h00)    begin errors++; $display("FAIL mid_resp got %h want 00", bus.resp); end
    if (bus.resp_rdy !== 1'b0) begin errors++; $display("FAIL mid_resp_rdy got %b want 0", bus.resp_rdy); end
    if (bus.tmo !== 1'b0)      begin errors++; $display("FAIL mid_tmo got %b want 0", bus.tmo); end
    rst = 1'b0;
    exp_tx.delete();
    repeat (20) @(posedge clk);
    #1;
    send_cmd(16'h00C3);
    wait_cmd_snt(n, found);
    checks++;
    if (!found) begin errors++; $display("FAIL mid_cmd_snt_new got none want pulse"); end
    exp_resp.push_back(RESP_DONE);
    send_rx(RESP_DONE, 1'b1);
    wait_resp(found);
    e = exp_resp.pop_front();
    checks += 2;
    if (!found || bus.resp !== e) begin errors++; $display("FAIL mid_resp_new got %h want %h", bus.resp, e); end
    if (exp_tx.size() != 0) begin errors++; $display("FAIL mid_tx_pending got %0d want 0", exp_tx.size()); end
  endtask

  task automatic test_clr_coincident();
    int n; bit found; logic [7:0] e;
    send_cmd(16'h0102);
    wait_cmd_snt(n, found);
    exp_resp.push_back(RESP_DONE);
    fork
      send_rx(RESP_DONE, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        bus.clr_resp_rdy = 1'b1;
        @(posedge clk); #1;
        bus.clr_resp_rdy = 1'b0;
      end
    join
    e = exp_resp.pop_front();
    checks += 3;
    if (bus.resp_rdy !== 1'b1) begin errors++; $display("FAIL coinc_resp_rdy got %b want 1", bus.resp_rdy); end
    if (bus.resp !== e)        begin errors++; $display("FAIL coinc_resp got %h want %h", bus.resp, e); end
    if (bus.busy !== 1'b0)     begin errors++; $display("FAIL coinc_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int n; int w; bit found; logic [7:0] e;
    send_cmd(16'h0304);
    wait_cmd_snt(n, found);
    exp_resp.push_back(RESP_DONE);
    fork
      send_rx(RESP_DONE, 1'b1);
      begin
        w = 0;
        while (bus.busy !== 1'b0 && w < 400) begin @(posedge clk); #1; w++; end
        send_cmd(16'h0506);
      end
    join
    e = exp_resp.pop_front();
    checks += 2;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", bus.busy); end
    if (bus.resp !== e)    begin errors++; $display("FAIL b2b_resp got %h want %h", bus.resp, e); end
    wait_cmd_snt(n, found);
    checks++;
    if (!found) begin errors++; $display("FAIL b2b_cmd_snt got none want pulse"); end
    exp_resp.push_back(RESP_DONE);
    send_rx(RESP_DONE, 1'b1);
    wait_resp(found);
    e = exp_resp.pop_front();
    repeat (50) @(posedge clk);
    #1;
    checks += 3;
    if (!found || bus.resp !== e) begin errors++; $display("FAIL b2b_resp2 got %h want %h", bus.resp, e); end
    if (bus.busy !== 1'b0)   begin errors++; $display("FAIL b2b_idle got %b want 0", bus.busy); end
    if (exp_tx.size() != 0)  begin errors++; $display("FAIL b2b_tx_pending got %0d want 0", exp_tx.size()); end
  endtask

  initial begin
    test_reset();
    test_send_resp();
    test_busy_ignore();
    test_timeout();
    test_framing();
    test_reset_mid();
    test_clr_coincident();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
